// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: memory access codes, datapath widths and the
// EX/MEM pipeline payload.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned MEMOP_W = 3;
  localparam int unsigned LANES   = XLEN / 8;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_WORD  = 3'b000,
    MEMOP_BYTE  = 3'b001,
    MEMOP_BYTEU = 3'b010,
    MEMOP_HALF  = 3'b011,
    MEMOP_HALFU = 3'b100
  } memop_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                mem_to_reg;
    logic                pc_to_reg;
    logic [MEMOP_W-1:0]  mem_op;
    logic [REG_AW-1:0]   rd;
    logic [XLEN-1:0]     alu;
    logic [XLEN-1:0]     mb;
    logic [XLEN-1:0]     pc;
  } exmem_t;

  // Natural alignment check on the two low address bits; unknown codes act as WORD.
  function automatic logic misaligned(input logic [MEMOP_W-1:0] op, input logic [1:0] lo);
    case (op)
      MEMOP_BYTE, MEMOP_BYTEU: return 1'b0;
      MEMOP_HALF, MEMOP_HALFU: return lo[0];
      default:                 return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// Word-organised data memory: byte-lane writes, whole-array synchronous clear,
// combinational read.
module dm
  import mips_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [LANES-1:0] be,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata_c
);

  logic [XLEN-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) mem_q[IDX_W'(i)] <= '0;
    end else if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem_q[idx];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, data memory access, load extension and
// write-back/forward muxing. Define DM_DISPLAY_EN to trace every performed DM write.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DM_WORDS    = 1024,
  parameter int unsigned PC_LINK_OFF = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                M_flush,
  input  logic [XLEN-1:0]     E_ALUResult,
  input  logic [XLEN-1:0]     E_mb,
  input  logic [REG_AW-1:0]   E_mrd,
  input  logic [XLEN-1:0]     E_PC,
  input  logic                E_RegWrite,
  input  logic                E_MemWrite,
  input  logic                E_MemToReg,
  input  logic                E_PcToReg,
  input  logic [MEMOP_W-1:0]  E_MemOp,
  output logic [REG_AW-1:0]   M_A3,
  output logic                M_RegWrite,
  output logic                M_MemToReg,
  output logic [XLEN-1:0]     M_FwdData,
  output logic [XLEN-1:0]     M_WD,
  output logic [XLEN-1:0]     M_PC,
  output logic                M_AdEL,
  output logic                M_AdES
);

  localparam int unsigned IDX_W = $clog2(DM_WORDS);

  exmem_t exmem_d, exmem_q;

  // A flush loads a bubble; reset is handled in the register itself.
  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = E_RegWrite;
    exmem_d.mem_write  = E_MemWrite;
    exmem_d.mem_to_reg = E_MemToReg;
    exmem_d.pc_to_reg  = E_PcToReg;
    exmem_d.mem_op     = E_MemOp;
    exmem_d.rd         = E_mrd;
    exmem_d.alu        = E_ALUResult;
    exmem_d.mb         = E_mb;
    exmem_d.pc         = E_PC;
    if (M_flush) exmem_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  logic [XLEN-1:0]  addr;
  logic             in_range;
  logic             mis;
  logic             dm_we;
  logic [LANES-1:0] be;
  logic [XLEN-1:0]  wdata;
  logic [XLEN-1:0]  rdata;
  logic [XLEN-1:0]  link;

  assign addr     = exmem_q.alu;
  assign in_range = addr[XLEN-1:2] < 30'(DM_WORDS);
  assign mis      = misaligned(exmem_q.mem_op, addr[1:0]);
  assign dm_we    = exmem_q.mem_write & ~mis & in_range;
  assign link     = exmem_q.pc + 32'(PC_LINK_OFF);

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = '1;
    wdata = exmem_q.mb;
    case (exmem_q.mem_op)
      MEMOP_HALF, MEMOP_HALFU: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{exmem_q.mb[15:0]}};
      end
      MEMOP_BYTE, MEMOP_BYTEU: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{exmem_q.mb[7:0]}};
      end
      default: ;
    endcase
  end

  dm #(
    .WORDS (DM_WORDS),
    .IDX_W (IDX_W)
  ) u_dm (
    .clk     (clk),
    .reset   (reset),
    .we      (dm_we),
    .idx     (addr[IDX_W+1:2]),
    .be      (be),
    .wdata   (wdata),
    .rdata_c (rdata)
  );

  logic [15:0]     half_sel;
  logic [7:0]      byte_sel;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] load_data;

  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  assign byte_sel = rdata[{addr[1:0], 3'b000} +: 8];

  always_comb begin
    load_ext = rdata;
    case (exmem_q.mem_op)
      MEMOP_BYTE:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_BYTEU: load_ext = {24'h0, byte_sel};
      MEMOP_HALF:  load_ext = {{16{half_sel[15]}}, half_sel};
      MEMOP_HALFU: load_ext = {16'h0, half_sel};
      default: ;
    endcase
  end

  assign load_data = (mis || !in_range) ? '0 : load_ext;

  assign M_A3       = exmem_q.rd;
  assign M_RegWrite = exmem_q.reg_write;
  assign M_MemToReg = exmem_q.mem_to_reg;
  assign M_PC       = exmem_q.pc;
  assign M_FwdData  = exmem_q.pc_to_reg ? link : exmem_q.alu;
  assign M_WD       = exmem_q.mem_to_reg ? load_data : M_FwdData;
  assign M_AdEL     = exmem_q.mem_to_reg & mis;
  assign M_AdES     = exmem_q.mem_write & mis;

`ifdef DM_DISPLAY_EN
  logic [XLEN-1:0] new_word;

  always_comb begin
    new_word = rdata;
    for (int b = 0; b < LANES; b++) begin
      if (be[b]) new_word[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && dm_we)
      $display("%0t @%h: *%h <= %h", $time, exmem_q.pc, {addr[XLEN-1:2], 2'b00}, new_word);
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a byte-addressed reference memory model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int unsigned DMW = 1024;

  logic        clk = 1'b0;
  logic        reset, M_flush;
  logic [31:0] E_ALUResult, E_mb, E_PC;
  logic [4:0]  E_mrd;
  logic        E_RegWrite, E_MemWrite, E_MemToReg, E_PcToReg;
  logic [2:0]  E_MemOp;
  logic [4:0]  M_A3;
  logic        M_RegWrite, M_MemToReg, M_AdEL, M_AdES;
  logic [31:0] M_FwdData, M_WD, M_PC;

  mem_stage #(.DM_WORDS(DMW), .PC_LINK_OFF(8)) dut (
    .clk(clk), .reset(reset), .M_flush(M_flush),
    .E_ALUResult(E_ALUResult), .E_mb(E_mb), .E_mrd(E_mrd), .E_PC(E_PC),
    .E_RegWrite(E_RegWrite), .E_MemWrite(E_MemWrite), .E_MemToReg(E_MemToReg),
    .E_PcToReg(E_PcToReg), .E_MemOp(E_MemOp),
    .M_A3(M_A3), .M_RegWrite(M_RegWrite), .M_MemToReg(M_MemToReg),
    .M_FwdData(M_FwdData), .M_WD(M_WD), .M_PC(M_PC),
    .M_AdEL(M_AdEL), .M_AdES(M_AdES)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, instruction in MEM as plain fields.
  logic [7:0]  mbyte [4*DMW];
  logic        s_rw, s_mw, s_m2r, s_p2r;
  logic [2:0]  s_op;
  logic [4:0]  s_rd;
  logic [31:0] s_alu, s_mb, s_pc;
  logic        live = 1'b0;

  function automatic int acc_size(input logic [2:0] op);
    case (op)
      MEMOP_BYTE, MEMOP_BYTEU: return 1;
      MEMOP_HALF, MEMOP_HALFU: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit m_mis(input logic [2:0] op, input logic [31:0] a);
    return (a % 32'(acc_size(op))) != 0;
  endfunction

  function automatic bit m_inr(input logic [31:0] a);
    return (a / 4) < DMW;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < acc_size(op); k++) v = v | (32'(mbyte[12'(a + 32'(k))]) << (8 * k));
    if (op == MEMOP_BYTE && v[7])  v = v | 32'hFFFF_FF00;
    if (op == MEMOP_HALF && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  always @(posedge clk) begin
    live <= 1'b1;
    if (reset) begin
      for (int i = 0; i < 4 * DMW; i++) mbyte[i] <= 8'h00;
      {s_rw, s_mw, s_m2r, s_p2r, s_op, s_rd, s_alu, s_mb, s_pc} <= '0;
    end else begin
      if (s_mw && !m_mis(s_op, s_alu) && m_inr(s_alu))
        for (int k = 0; k < acc_size(s_op); k++) mbyte[12'(s_alu + 32'(k))] <= s_mb[8*k +: 8];
      if (M_flush)
        {s_rw, s_mw, s_m2r, s_p2r, s_op, s_rd, s_alu, s_mb, s_pc} <= '0;
      else begin
        s_rw <= E_RegWrite; s_mw <= E_MemWrite; s_m2r <= E_MemToReg; s_p2r <= E_PcToReg;
        s_op <= E_MemOp; s_rd <= E_mrd; s_alu <= E_ALUResult; s_mb <= E_mb; s_pc <= E_PC;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_fwd, e_wd;
    if (live) begin
      e_fwd = s_p2r ? s_pc + 32'd8 : s_alu;
      if (s_m2r) e_wd = (m_mis(s_op, s_alu) || !m_inr(s_alu)) ? 32'h0 : m_load(s_op, s_alu);
      else       e_wd = e_fwd;
      check("cyc_A3",       32'(M_A3),       32'(s_rd));
      check("cyc_RegWrite", 32'(M_RegWrite), 32'(s_rw));
      check("cyc_MemToReg", 32'(M_MemToReg), 32'(s_m2r));
      check("cyc_PC",       M_PC,            s_pc);
      check("cyc_FwdData",  M_FwdData,       e_fwd);
      check("cyc_WD",       M_WD,            e_wd);
      check("cyc_AdEL",     32'(M_AdEL),     32'(s_m2r && m_mis(s_op, s_alu)));
      check("cyc_AdES",     32'(M_AdES),     32'(s_mw && m_mis(s_op, s_alu)));
    end
  end

  // Drives one instruction into EX; returns once it sits in MEM.
  task automatic issue(input bit fl, mw, rw, m2r, p2r, input logic [2:0] op,
                       input logic [31:0] a, d, input logic [4:0] rd, input logic [31:0] pc);
    M_flush = fl; E_MemWrite = mw; E_RegWrite = rw; E_MemToReg = m2r; E_PcToReg = p2r;
    E_MemOp = op; E_ALUResult = a; E_mb = d; E_mrd = rd; E_PC = pc;
    @(posedge clk);
    #2;
  endtask

  task automatic nop();                                              issue(0, 0, 0, 0, 0, MEMOP_WORD, 0, 0, 0, 0);     endtask
  task automatic st(input logic [2:0] op, input logic [31:0] a, d);  issue(0, 1, 0, 0, 0, op, a, d, 0, 32'h400);        endtask
  task automatic ld(input logic [2:0] op, input logic [31:0] a);     issue(0, 0, 1, 1, 0, op, a, 0, 5'd8, 32'h404);     endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    nop();
    nop();
    check("rst_A3", 32'(M_A3), 0);
    check("rst_RegWrite", 32'(M_RegWrite), 0);
    check("rst_MemToReg", 32'(M_MemToReg), 0);
    check("rst_PC", M_PC, 0);
    check("rst_Fwd", M_FwdData, 0);
    check("rst_WD", M_WD, 0);
    check("rst_AdEL", 32'(M_AdEL), 0);
    check("rst_AdES", 32'(M_AdES), 0);
    reset = 1'b0;

    st(MEMOP_WORD, 32'h10, 32'h1234_5678);
    st(MEMOP_WORD, 32'h20, 32'hCAFE_F00D);
    ld(MEMOP_WORD, 32'h10);            check("lw_10", M_WD, 32'h1234_5678);

    st(MEMOP_BYTE, 32'h11, 32'hFFFF_FFAB);
    ld(MEMOP_WORD, 32'h10);            check("sb_word", M_WD, 32'h1234_AB78);
    ld(MEMOP_BYTE, 32'h11);            check("lb_11", M_WD, 32'hFFFF_FFAB);
    ld(MEMOP_BYTEU, 32'h11);           check("lbu_11", M_WD, 32'h0000_00AB);
    ld(MEMOP_HALF, 32'h12);            check("lh_12", M_WD, 32'h0000_1234);
    st(MEMOP_HALF, 32'h16, 32'h5555_8001);
    ld(MEMOP_HALF, 32'h16);            check("lh_16", M_WD, 32'hFFFF_8001);
    ld(MEMOP_HALFU, 32'h16);           check("lhu_16", M_WD, 32'h0000_8001);
    ld(MEMOP_WORD, 32'h14);            check("sh_word", M_WD, 32'h8001_0000);

    st(MEMOP_WORD, 32'h22, 32'h9999_9999);
    check("sw_mis_AdES", 32'(M_AdES), 1);
    nop();                             check("AdES_drop", 32'(M_AdES), 0);
    ld(MEMOP_WORD, 32'h20);            check("w20_kept", M_WD, 32'hCAFE_F00D);
    ld(MEMOP_HALF, 32'h23);            check("lh_mis_AdEL", 32'(M_AdEL), 1);
    check("lh_mis_WD", M_WD, 0);

    issue(0, 0, 1, 0, 1, MEMOP_WORD, 32'h55, 0, 5'd31, 32'h3000);
    check("jal_WD", M_WD, 32'h3008);
    check("jal_Fwd", M_FwdData, 32'h3008);
    check("jal_A3", 32'(M_A3), 31);
    issue(0, 0, 1, 0, 1, MEMOP_WORD, 32'h55, 0, 5'd31, 32'hFFFF_FFFC);
    check("jal_wrap", M_WD, 32'h4);
    issue(0, 0, 1, 1, 1, MEMOP_WORD, 32'h10, 0, 5'd2, 32'h3000);
    check("both_WD", M_WD, 32'h1234_AB78);

    issue(1, 1, 1, 0, 0, MEMOP_WORD, 32'h10, 32'hDEAD_BEEF, 5'd5, 32'h200);
    check("flush_RegWrite", 32'(M_RegWrite), 0);
    ld(MEMOP_WORD, 32'h10);            check("flush_nowrite", M_WD, 32'h1234_AB78);

    st(MEMOP_WORD, 32'h40, 32'h1111_2222);
    ld(MEMOP_WORD, 32'h40);            check("b2b_lw", M_WD, 32'h1111_2222);
    st(MEMOP_BYTE, 32'h41, 32'h0000_007F);
    ld(MEMOP_BYTEU, 32'h41);           check("b2b_lbu", M_WD, 32'h0000_007F);

    st(MEMOP_WORD, 32'h1000, 32'h5555_5555);
    check("oor_AdES", 32'(M_AdES), 0);
    ld(MEMOP_WORD, 32'h1000);          check("oor_lw", M_WD, 0);
    check("oor_AdEL", 32'(M_AdEL), 0);
    ld(MEMOP_WORD, 32'h0);             check("oor_alias", M_WD, 0);

    reset = 1'b1;
    nop();
    reset = 1'b0;
    ld(MEMOP_WORD, 32'h10);            check("dm_cleared", M_WD, 0);
    nop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and the word-organised data memory (DM).
- Performs sw/sh/sb stores and lw/lh/lhu/lb/lbu loads with extension.
- Presents write-back data, destination register and forwarding values to the MEM/WB register and the hazard unit.

Parameters:
- DM_WORDS, 1024, number of 32-bit words in DM; word index = address[11:2] at default.
- PC_LINK_OFF, 8, offset added to the captured PC for link write-back (jal/jalr).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- M_flush  in  1  loads a bubble into the EX/MEM register instead of EX values
- E_ALUResult  in  32  ALU result from execute; store/load address
- E_mb  in  32  store data (forwarded rt value)
- E_mrd  in  5  destination register chosen in execute
- E_PC  in  32  PC of the instruction in execute
- E_RegWrite  in  1  instruction writes the register file
- E_MemWrite  in  1  instruction is a store
- E_MemToReg  in  1  write-back source is load data
- E_PcToReg  in  1  write-back source is PC+PC_LINK_OFF
- E_MemOp  in  3  access width/sign code (package constants)
- M_A3  out  5  registered destination register
- M_RegWrite  out  1  registered register-file write enable
- M_MemToReg  out  1  registered; the hazard unit uses it to detect load-use
- M_FwdData  out  32  forwarding value: PC+PC_LINK_OFF if PcToReg, else ALUResult
- M_WD  out  32  write-back data: load data if MemToReg, PC+PC_LINK_OFF if PcToReg, else ALUResult
- M_PC  out  32  registered PC
- M_AdEL  out  1  misaligned-load flag, combinational from registered state
- M_AdES  out  1  misaligned-store flag, combinational from registered state

Behaviour:
- EX/MEM register:
  - On clk rise: if reset or M_flush, all registered fields are cleared to 0. This forces M_RegWrite, M_MemWrite, M_MemToReg and M_PcToReg to 0 and M_A3, M_PC and the internal ALUResult/mb/MemOp registers to 0.
  - Otherwise all E_* inputs are captured. EX values are visible on M_* one cycle after capture.
  - reset takes priority over M_flush.
- Outputs after reset: M_A3=0, M_RegWrite=0, M_MemToReg=0, M_PC=0, M_FwdData=0, M_WD=0, M_AdEL=0, M_AdES=0.
- DM reset: on a reset edge every DM word is set to 0 synchronously; no store occurs in that cycle.
- DM write:
  - Occurs on clk rise when registered MemWrite=1, the access is aligned, and the word index is < DM_WORDS.
  - MemOp WORD writes the full word.
  - HALF writes lane addr[1] (bits 15:0 or 31:16) with mb[15:0].
  - BYTE writes lane addr[1:0] with mb[7:0].
  - Unwritten lanes are preserved.
- DM read:
  - Combinational from the registered address.
  - WORD returns the whole word.
  - HALF/HALFU select the halfword by addr[1], then sign-extend / zero-extend.
  - BYTE/BYTEU select the byte by addr[1:0], then sign-extend / zero-extend.
  - A read of the word being stored in the same cycle returns the old contents; the new value is visible next cycle.
- Alignment:
  - WORD requires addr[1:0]=0; HALF/HALFU require addr[0]=0.
  - A violation asserts M_AdEL (load) or M_AdES (store) for the cycle the instruction is in MEM.
  - A misaligned store is suppressed. A misaligned load returns 0 in M_WD.
- Out of range: word index >= DM_WORDS suppresses stores and returns 0 for loads; no flag is raised.
- Arithmetic: PC+PC_LINK_OFF is 32-bit, wrapping modulo 2^32. MemToReg and PcToReg are never both 1; if they are, MemToReg wins.

Optional Feature:
- Macro: DM_DISPLAY_EN.
- Defined: every performed DM write prints one line via $display: time, M_PC, byte address of the word, and the full new word value. Format: "@PC: *ADDR <= DATA" in hex. Suppressed writes print nothing.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - the MemOp codes: WORD=3'b000, BYTE=3'b001, BYTEU=3'b010, HALF=3'b011, HALFU=3'b100;
  - the width constants.
- One sub-module, dm: the memory array with byte-lane write and synchronous clear.
- Load extension and muxing stay in mem_stage.

Test Plan:
- Reset, then store path. Stimulus: reset high for 2 cycles, then release; E_MemWrite=1, WORD, addr 0x10, mb=0x12345678. Required: all outputs 0 after reset; the next WORD load of 0x10 gives M_WD=0x12345678.
- Byte and half store/load. Stimulus: word 0x10 holds 0x12345678; sb of 0xAB at 0x11. Required: word reads 0x1234AB78; lb 0x11 gives 0xFFFFFFAB; lbu 0x11 gives 0x000000AB; lh 0x12 gives 0x00001234.
- Misaligned. Stimulus: sw at 0x22. Required: M_AdES=1 for one cycle and word 0x20 unchanged. Stimulus: lh at 0x23. Required: M_AdEL=1 and M_WD=0.
- Link and forward. Stimulus: E_PcToReg=1, E_PC=0x3000, E_mrd=31, E_RegWrite=1. Required: next cycle M_WD=M_FwdData=0x3008 and M_A3=31.
- Flush and read-during-write. Stimulus: M_flush with E_MemWrite=1. Required: no DM change and M_RegWrite=0. Stimulus: back-to-back sw then lw to the same address. Required: the lw returns the new value.
- Out of range. Stimulus: sw at address 4*DM_WORDS. Required: no write and no flag; a lw of that address returns 0.
